// File: rtl/tp_gpio_edge_capture_if.sv
// tp_gpio_edge_capture_if: Avalon-MM word-addressed slave bus used by the test-point GPIO ports
interface tp_gpio_edge_capture_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/tp_gpio_edge_capture.sv
// tp_gpio_edge_capture: synchronised test-point inputs with sticky edge capture and maskable irq
module tp_gpio_edge_capture #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   tp_gpio_edge_capture_if.slave bus,
   input  logic [WIDTH-1:0]      in_port,
   output logic                  irq
);
   localparam int AW = $clog2(SYNC_STAGES + 2);
   localparam logic [AW-1:0] ARM_MAX = AW'(SYNC_STAGES + 1);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
   logic [WIDTH-1:0] sync_q, prev_q, cap, irqmask, edge_raw, edge_v, clr, rd_mux;
   logic [AW-1:0] arm_cnt;
   logic wr, armed, unused_wd;
   assign sync_q = sync_r[SYNC_STAGES-1];
   assign wr = bus.chipselect & ~bus.write_n;
   assign armed = arm_cnt == ARM_MAX;
   assign unused_wd = ^bus.writedata;
   // edges stay masked until the chain and prev_q hold live input values
   always_comb begin
      edge_raw = EDGE_TYPE == 0 ? sync_q & ~prev_q : EDGE_TYPE == 1 ? ~sync_q & prev_q : sync_q ^ prev_q;
      edge_v = armed ? edge_raw : '0;
      clr = (wr && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;
      rd_mux = bus.address == 3'd0 ? sync_q : bus.address == 3'd2 ? irqmask : bus.address == 3'd3 ? cap : '0;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync_r <= '0;
         prev_q <= '0;
         arm_cnt <= '0;
         cap <= '0;
         irqmask <= '0;
         bus.readdata <= '0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], in_port};
         prev_q <= sync_q;
         if (!armed) arm_cnt <= arm_cnt + 1'b1;
         cap <= (cap & ~clr) | edge_v;
         if (wr && bus.address == 3'd2) irqmask <= bus.writedata[WIDTH-1:0];
         bus.readdata <= 32'(rd_mux);
      end
   assign irq = |(cap & irqmask);
endmodule

// File: tb/tb_tp_gpio_edge_capture.sv
// tb_tp_gpio_edge_capture: rising-edge and any-edge ports driven by directed and random steps,
// checked every cycle against a sample-history reference model
module tb_tp_gpio_edge_capture;
   localparam int S = 2;
   logic clk = 1'b0, reset = 1'b0;
   logic [7:0] in0 = 8'h00, in1 = 8'h00;
   logic irq0, irq1;
   int n_vec = 0, n_err = 0;
   logic [7:0] hist [2][S+1];
   logic [7:0] cap_m [2], mask_m [2], rd_m [2];
   int cnt [2];
   logic [2:0] holes [5] = '{3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

   tp_gpio_edge_capture_if b0 (), b1 ();
   tp_gpio_edge_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(0)) u0 (
      .clk(clk), .reset(reset), .bus(b0), .in_port(in0), .irq(irq0));
   tp_gpio_edge_capture #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_TYPE(2)) u1 (
      .clk(clk), .reset(reset), .bus(b1), .in_port(in1), .irq(irq1));

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i <= S; i++) hist[d][i] = 8'h00;
         cap_m[d] = 8'h00;
         mask_m[d] = 8'h00;
         rd_m[d] = 8'h00;
         cnt[d] = 0;
      end
   endtask

   task automatic check_model();
      chk("rd0", b0.readdata, {24'd0, rd_m[0]});
      chk("rd1", b1.readdata, {24'd0, rd_m[1]});
      chk("irq0", {31'd0, irq0}, {31'd0, |(cap_m[0] & mask_m[0])});
      chk("irq1", {31'd0, irq1}, {31'd0, |(cap_m[1] & mask_m[1])});
   endtask

   task automatic drive(int d, logic cs, logic wn, logic [2:0] a, logic [31:0] wd);
      if (d == 0) begin
         b0.chipselect = cs; b0.write_n = wn; b0.address = a; b0.writedata = wd;
      end else begin
         b1.chipselect = cs; b1.write_n = wn; b1.address = a; b1.writedata = wd;
      end
   endtask

   // hist[d][k] is the input sampled k edges ago; sync_q is S-1 edges old, prev_q S edges old
   task automatic tick();
      logic [7:0] iv [2];
      logic [2:0] a [2];
      logic w [2];
      logic [7:0] wd [2];
      logic [7:0] sy, pv, ev, clr;
      iv[0] = in0; iv[1] = in1;
      a[0] = b0.address; a[1] = b1.address;
      w[0] = b0.chipselect & ~b0.write_n; w[1] = b1.chipselect & ~b1.write_n;
      wd[0] = b0.writedata[7:0]; wd[1] = b1.writedata[7:0];
      @(posedge clk);
      if (reset) model_reset();
      else for (int d = 0; d < 2; d++) begin
         sy = hist[d][S-1];
         pv = hist[d][S];
         ev = cnt[d] <= S ? 8'h00 : d == 0 ? sy & ~pv : sy ^ pv;
         clr = (w[d] && a[d] == 3'd3) ? wd[d] : 8'h00;
         rd_m[d] = a[d] == 3'd0 ? sy : a[d] == 3'd2 ? mask_m[d] : a[d] == 3'd3 ? cap_m[d] : 8'h00;
         cap_m[d] = (cap_m[d] & ~clr) | ev;
         if (w[d] && a[d] == 3'd2) mask_m[d] = wd[d];
         for (int i = S; i > 0; i--) hist[d][i] = hist[d][i-1];
         hist[d][0] = iv[d];
         if (cnt[d] < 1000) cnt[d]++;
      end
      #1;
      check_model();
   endtask

   task automatic cyc(int d, logic cs, logic wn, logic [2:0] a, logic [31:0] wd);
      drive(d, cs, wn, a, wd);
      tick();
      drive(d, 1'b0, 1'b1, a, 32'd0);
   endtask

   initial begin
      drive(0, 1'b0, 1'b1, 3'd0, 32'd0);
      drive(1, 1'b0, 1'b1, 3'd0, 32'd0);
      model_reset();
      in0 = 8'hFF;
      in1 = 8'hFF;
      #1 reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("reset_data0", b0.readdata, 32'hFF);
      chk("reset_data1", b1.readdata, 32'hFF);
      cyc(0, 1'b0, 1'b1, 3'd3, 32'd0);
      chk("reset_cap0", b0.readdata, 32'h00);
      chk("reset_irq0", {31'd0, irq0}, 32'd0);

      in0 = 8'h00;
      repeat (4) tick();
      cyc(0, 1'b1, 1'b0, 3'd2, 32'h01);
      drive(0, 1'b0, 1'b1, 3'd3, 32'd0);
      in0 = 8'h01;
      tick();
      chk("rise_e1", {31'd0, irq0}, 32'd0);
      tick();
      chk("rise_e2", {31'd0, irq0}, 32'd0);
      tick();
      chk("rise_e3", {31'd0, irq0}, 32'd1);
      tick();
      chk("rise_cap", b0.readdata, 32'h01);

      in0 = 8'h05;
      repeat (4) tick();
      chk("w1c_pre", b0.readdata, 32'h05);
      cyc(0, 1'b1, 1'b0, 3'd3, 32'h04);
      tick();
      chk("w1c_bit2", b0.readdata, 32'h01);
      cyc(0, 1'b1, 1'b0, 3'd3, 32'h01);
      chk("w1c_irq", {31'd0, irq0}, 32'd0);
      tick();
      chk("w1c_bit0", b0.readdata, 32'h00);

      in0 = 8'h07;
      tick();
      tick();
      cyc(0, 1'b1, 1'b0, 3'd3, 32'h02);
      tick();
      chk("set_wins", b0.readdata, 32'h02);

      drive(1, 1'b0, 1'b1, 3'd3, 32'd0);
      in1 = 8'h7F;
      repeat (4) tick();
      cyc(1, 1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF);
      in1 = 8'hFF;
      repeat (4) tick();
      in1 = 8'h7F;
      repeat (4) tick();
      chk("any_cap", b1.readdata, 32'h80);
      chk("any_irq_masked", {31'd0, irq1}, 32'd0);
      cyc(1, 1'b1, 1'b0, 3'd2, 32'h80);
      chk("any_irq_unmasked", {31'd0, irq1}, 32'd1);

      foreach (holes[i]) begin
         drive(0, 1'b0, 1'b1, holes[i], 32'd0);
         tick();
         chk($sformatf("hole_%0d", holes[i]), b0.readdata, 32'h00);
      end
      cyc(0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FFFF);
      tick();
      chk("data_ro", b0.readdata, 32'h07);

      cyc(0, 1'b1, 1'b0, 3'd2, 32'hFF);
      in0 = 8'h00;
      repeat (4) tick();
      in0 = 8'hFF;
      repeat (4) tick();
      drive(0, 1'b0, 1'b1, 3'd3, 32'd0);
      tick();
      chk("pre_rst_cap", b0.readdata, 32'hFF);
      chk("pre_rst_irq", {31'd0, irq0}, 32'd1);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("arst_rd0", b0.readdata, 32'h00);
      chk("arst_irq0", {31'd0, irq0}, 32'd0);
      chk("arst_rd1", b1.readdata, 32'h00);
      chk("arst_irq1", {31'd0, irq1}, 32'd0);
      tick();
      reset = 1'b0;

      repeat (600) begin
         if ($urandom_range(0, 2) == 0) in0 = 8'($urandom);
         if ($urandom_range(0, 2) == 0) in1 = 8'($urandom);
         for (int d = 0; d < 2; d++)
            drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
         reset = $urandom_range(0, 99) == 0;
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
